// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: port bundle between the arbiter and the shared Booth multiplier
interface mult_share_arbiter_if #(parameter int L_word = 4);
  logic                  mult_Start;
  logic                  mult_Ready;
  logic [L_word-1:0]     mult_A;
  logic [L_word-1:0]     mult_x;
  logic [2*L_word-1:0]   mult_product;
  modport master(output mult_Start, mult_A, mult_x, input mult_Ready, mult_product);
  modport slave(input mult_Start, mult_A, mult_x, output mult_Ready, mult_product);
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one multiplier among N_REQ requesters
module mult_share_arbiter #(
  parameter int L_word  = 4,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4*L_word+8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*L_word-1:0]   A_in,
  input  logic [N_REQ*L_word-1:0]   x_in,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          done,
  output logic [2*L_word-1:0]       result,
  output logic                      err,
  output logic                      busy,
  mult_share_arbiter_if.master      m
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_DROP = 3'd2, WAIT_DONE = 3'd3, DELIVER = 3'd4;
  logic [2:0]        state;
  logic [PW-1:0]     rr_ptr, g, pick, cand;
  logic [CW-1:0]     cnt;
  logic              hit, err_r, tmo;
  logic [L_word-1:0] a_r, x_r;
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % N_REQ);
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end
  assign tmo          = cnt == CW'(TIMEOUT-1);
  assign ack          = (state == ISSUE)   ? N_REQ'(1) << g : '0;
  assign done         = (state == DELIVER) ? N_REQ'(1) << g : '0;
  assign err          = (state == DELIVER) && err_r;
  assign busy         = state != IDLE;
  assign m.mult_Start = state == ISSUE;
  assign m.mult_A     = a_r;
  assign m.mult_x     = x_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      g      <= '0;
      cnt    <= '0;
      result <= '0;
      a_r    <= '0;
      x_r    <= '0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hit && m.mult_Ready) begin
          g      <= pick;
          rr_ptr <= pick == PW'(N_REQ-1) ? '0 : pick + 1'b1;
          a_r    <= A_in[pick*L_word +: L_word];
          x_r    <= x_in[pick*L_word +: L_word];
          err_r  <= 1'b0;
          state  <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_DROP;
        end
        WAIT_DROP: if (!m.mult_Ready) begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end else if (tmo) begin
          result <= '0;
          err_r  <= 1'b1;
          state  <= DELIVER;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (m.mult_Ready) begin
          result <= m.mult_product;
          state  <= DELIVER;
        end else if (tmo) begin
          result <= '0;
          err_r  <= 1'b1;
          state  <= DELIVER;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed checks of the multiplier-sharing arbiter
module tb_mult_share_arbiter;
  localparam int L = 4, N = 4, TO = 4*L+8, RUN = 3;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0;
  logic [N*L-1:0] A_in = '0, x_in = '0;
  logic [N-1:0] ack, done;
  logic [2*L-1:0] result;
  logic err, busy;
  mult_share_arbiter_if #(.L_word(L)) mif();
  mult_share_arbiter #(.L_word(L), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .A_in(A_in), .x_in(x_in), .ack(ack), .done(done),
    .result(result), .err(err), .busy(busy), .m(mif.master));
  always #5 clk = ~clk;
  logic stuck = 0, mrdy = 1;
  logic [2*L-1:0] mprod = '0, pend = '0;
  int run = 0;
  wire signed [2*L-1:0] sa = {{L{mif.mult_A[L-1]}}, mif.mult_A};
  wire signed [2*L-1:0] sx = {{L{mif.mult_x[L-1]}}, mif.mult_x};
  assign mif.mult_Ready = mrdy;
  assign mif.mult_product = mprod;
  always @(posedge clk) begin
    if (run > 0) begin
      run <= run - 1;
      if (run == 1) begin
        mrdy  <= 1'b1;
        mprod <= pend;
      end
    end else if (mif.mult_Start && !stuck) begin
      mrdy <= 1'b0;
      run  <= RUN;
      pend <= sa * sx;
    end
  end
  function automatic int idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction
  int cyc = 0, starts = 0, errs = 0, viol = 0;
  int ack_q[$], ack_c[$], done_q[$], done_c[$], res_q[$], err_q[$];
  always @(negedge clk) begin
    cyc++;
    if (ack != 0) begin ack_q.push_back(idx(ack)); ack_c.push_back(cyc); end
    if (done != 0) begin
      done_q.push_back(idx(done)); done_c.push_back(cyc);
      res_q.push_back(int'(result)); err_q.push_back(int'(err));
    end
    if (mif.mult_Start) starts++;
    if (err) errs++;
    if (!$onehot0(ack) || !$onehot0(done) || (mif.mult_Start != (ack != 0)) || (err && done == 0)) viol++;
  end
  int total = 0, passed = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick; @(negedge clk); #1; endtask
  task automatic wait_acks(input int n);
    for (int k = 0; k < 300 && ack_q.size() < n; k++) tick;
    chk("ack_wait", ack_q.size(), n);
  endtask
  task automatic wait_dones(input int n);
    for (int k = 0; k < 300 && done_q.size() < n; k++) tick;
    chk("done_wait", done_q.size(), n);
  endtask
  task automatic do_reset;
    reset = 1; tick; tick; reset = 0; tick;
  endtask
  int nd, ne, ns;
  int order[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp3[4] = '{8'h05, 8'hFA, 8'h31, 8'h08};
  int alt[4] = '{0, 2, 0, 2};
  initial begin
    #200000 $display("FAIL watchdog"); $fatal(1);
  end
  initial begin
    repeat (3) tick;
    chk("rst_busy", busy, 0); chk("rst_ack", ack, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_start", mif.mult_Start, 0); chk("rst_result", result, 0);
    chk("rst_A", mif.mult_A, 0); chk("rst_x", mif.mult_x, 0);
    reset = 0; tick;
    A_in = 16'h0003; x_in = 16'h0002; req = 4'b0001;
    wait_acks(1); req = '0;
    chk("t1_ack_idx", ack_q[0], 0);
    wait_dones(1);
    chk("t1_done_idx", done_q[0], 0); chk("t1_res", res_q[0], 8'h06);
    chk("t1_err", err_q[0], 0); chk("t1_starts", starts, 1);
    tick; chk("t1_idle", busy, 0);
    A_in = 16'h0008; x_in = 16'h000F; req = 4'b0001;
    wait_acks(2); req = '0; wait_dones(2);
    chk("t2_res", res_q[1], 8'h08); chk("t2_err", err_q[1], 0);
    do_reset;
    A_in = 16'hE721; x_in = 16'hC7D5; req = 4'hF;
    wait_acks(7); req = '0; wait_dones(7);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_ack%0d", k), ack_q[2+k], order[k]);
      chk($sformatf("t3_done%0d", k), done_q[2+k], order[k]);
      chk($sformatf("t3_res%0d", k), res_q[2+k], exp3[order[k]]);
    end
    do_reset;
    req = 4'b0101;
    wait_acks(11); req = '0; wait_dones(11);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_ack%0d", k), ack_q[7+k], alt[k]);
    tick;
    stuck = 1; req = 4'b0001;
    wait_acks(12); req = '0; wait_dones(12);
    chk("t5_idx", done_q[11], 0); chk("t5_err", err_q[11], 1); chk("t5_res", res_q[11], 0);
    chk("t5_latency", done_c[11] - ack_c[11], TO + 1);
    tick; chk("t5_idle", busy, 0);
    stuck = 0; tick;
    req = 4'b0100;
    wait_acks(13); req = '0;
    chk("t6_ack_idx", ack_q[12], 2);
    tick; tick;
    reset = 1; tick;
    chk("t6_busy", busy, 0); chk("t6_done", done, 0); chk("t6_err", err, 0);
    reset = 0;
    nd = done_q.size(); ne = errs; ns = starts;
    repeat (10) tick;
    chk("t6_no_done", done_q.size(), nd); chk("t6_no_err", errs, ne); chk("t6_no_start", starts, ns);
    req = 4'hF;
    wait_acks(14); req = '0;
    chk("t6_regrant", ack_q[13], 0);
    wait_dones(13);
    chk("t6_res", res_q[12], 8'h05);
    chk("invariants", viol, 0); chk("err_total", errs, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter L_word, default 4, giving the operand width in bits of the shared multiplier.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (range 2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 4*L_word+8, giving the maximum cycles allowed in each wait state.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: one clock; reset is synchronous and active-high.
REQ-006 Port req SHALL be an input, N_REQ bits: per-requester operation request, level, held until ack.
REQ-007 Port A_in SHALL be an input, N_REQ*L_word bits: multiplicand of requester i at slice [i*L_word +: L_word].
REQ-008 Port x_in SHALL be an input, N_REQ*L_word bits: multiplier of requester i, packed as A_in.
REQ-009 Port ack SHALL be an output, N_REQ bits: one-cycle pulse, operands of requester i captured.
REQ-010 Port done SHALL be an output, N_REQ bits: one-cycle pulse, result for requester i valid.
REQ-011 Port result SHALL be an output, 2*L_word bits: last delivered product, held until next delivery.
REQ-012 Port err SHALL be an output, 1 bit: one-cycle pulse coincident with done on a timed-out operation.
REQ-013 Port busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-014 Port mult_Start SHALL be an output, 1 bit: Start to the shared Booth multiplier.
REQ-015 Ports mult_A and mult_x SHALL be outputs, L_word bits each: registered operands to the multiplier.
REQ-016 Port mult_Ready SHALL be an input, 1 bit: multiplier Ready; high = idle/product valid.
REQ-017 Port mult_product SHALL be an input, 2*L_word bits: multiplier product, valid when mult_Ready high after a run.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_DROP, WAIT_DONE, DELIVER.
REQ-019 IDLE: if any req bit is high and mult_Ready=1, SHALL grant one requester, latch its A/x into mult_A/mult_x, go to ISSUE; else stay.
REQ-020 Grant SHALL be round-robin: search starts at pointer rr_ptr, increasing index with wrap N_REQ-1 -> 0.
REQ-021 On grant of index g, rr_ptr SHALL become (g+1) mod N_REQ.
REQ-022 ISSUE (exactly one cycle): mult_Start=1 and ack[g]=1; next state WAIT_DROP.
REQ-023 WAIT_DROP: on mult_Ready=0 go to WAIT_DONE; mult_Start=0.
REQ-024 WAIT_DONE: on mult_Ready=1 capture mult_product into result, go to DELIVER.
REQ-025 DELIVER (exactly one cycle): done[g]=1; next state IDLE; a new grant is possible the cycle after DELIVER.
REQ-026 A wait-cycle counter SHALL clear on entry to WAIT_DROP and WAIT_DONE; if it reaches TIMEOUT, go to DELIVER with result=0 and err=1 alongside done[g].
REQ-027 At most one ack bit and one done bit SHALL be high in any cycle; mult_Start SHALL be high only in ISSUE.
REQ-028 The block SHALL perform no arithmetic; result is mult_product bit-for-bit (signed, as produced by the multiplier).
REQ-029 req changes outside IDLE SHALL be ignored; a req dropped before grant SHALL never be acked.
REQ-030 A requester SHALL treat ack as consumption of its request; a req still high after ack is a new request.
REQ-031 Best-case latency, IDLE grant edge to done pulse: 3 cycles + multiplier run length.

Reset
REQ-032 While reset=1 at a rising edge: state<=IDLE, rr_ptr<=0, counter<=0, result<=0, mult_A<=0, mult_x<=0.
REQ-033 During and after reset, ack, done, err, busy, mult_Start SHALL be 0 until a new grant.
REQ-034 Reset in any non-IDLE state SHALL abandon the operation: no done, no err, no re-issue of mult_Start.

Verification
REQ-035 req=0001, A0=4'h3, x0=4'h2 -> ack[0] one cycle, one mult_Start pulse, then done[0] with result=8'h06.
REQ-036 req=0001, A0=4'h8, x0=4'hF (-8 * -1) -> done[0], result=8'h08.
REQ-037 req=1111 held after each ack, distinct operands -> grants in order 0,1,2,3,0; one done per ack, results match.
REQ-038 req=0101 held continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never acked.
REQ-039 Multiplier model holds mult_Ready=1 after Start -> after TIMEOUT cycles done[g]=1, err=1, result=8'h00, FSM back in IDLE.
REQ-040 reset=1 for one cycle during WAIT_DONE -> busy=0 next cycle, no done/err pulse, next req granted to index 0 first.
